// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: RV32I load/store size codes,
// FSM state encoding and the wait-state limit.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Largest wait-state count the 4-bit counter can hold.
  localparam int WAIT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data memory.
// Stores: places right-justified data on the addressed lanes and builds the
// byte-enable mask. Loads: shifts the addressed bytes down and sign- or
// zero-extends them. Illegal size/alignment combinations raise o_misalign and
// suppress both the write mask and the load data.
module lsu_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_adr,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wd,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [31:0] w_shift;

  // Decode size/sign, steer lanes and flag illegal accesses.
  always_comb begin
    o_be       = '0;
    o_wdata    = '0;
    o_rdata    = '0;
    o_misalign = 1'b0;
    w_shift    = i_rword >> {i_adr, 3'b000};
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be    = 4'b0001 << i_adr;
        o_wdata = {4{i_wd[7:0]}};
        o_rdata = {{24{w_shift[7] & ~i_funct3[2]}}, w_shift[7:0]};
      end
      F3_H, F3_HU: begin
        o_misalign = i_adr[0];
        o_be       = 4'b0011 << {i_adr[1], 1'b0};
        o_wdata    = {2{i_wd[15:0]}};
        o_rdata    = {{16{w_shift[15] & ~i_funct3[2]}}, w_shift[15:0]};
      end
      F3_W: begin
        o_misalign = |i_adr;
        o_be       = 4'b1111;
        o_wdata    = i_wd;
        o_rdata    = i_rword;
      end
      default: o_misalign = 1'b1;
    endcase
    // An erroring access must neither write nor return data.
    if (o_misalign) begin
      o_be    = '0;
      o_rdata = '0;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-port RV32I data memory seen from the M stage. One access in flight;
// the array is touched on the edge that enters RESP, and ack/misalign/memDataRD
// are registered on that same edge. busy stalls the pipeline until RESP.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 1   // 0..WAIT_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] memAdrs,
  input  logic [31:0] memDataWD,
  output logic [31:0] memDataRD,
  output logic        ack,
  output logic        busy,
  output logic        misalign
);

  localparam int AW = ADDR_WIDTH + 2;

  state_e            r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [AW-1:0]     r_adr;
  logic [31:0]       r_wd;
  logic              r_ack;
  logic              r_mis;
  logic [31:0]       r_rd;
  logic [31:0]       r_mem [2**ADDR_WIDTH];

  logic              w_idle;
  logic              w_we;
  logic [2:0]        w_f3;
  logic [AW-1:0]     w_adr;
  logic [31:0]       w_wd;
  logic              w_to_resp;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rdata;
  logic              w_mis;
  logic              w_unused_hi;

  assign w_unused_hi = ^memAdrs[31:AW];
  assign w_idle      = (r_state == IDLE);

  // With zero wait states RESP is entered on the edge that samples req, so the
  // array must see the live inputs; otherwise it sees the latched request.
  assign w_we  = w_idle ? we              : r_we;
  assign w_f3  = w_idle ? funct3          : r_f3;
  assign w_adr = w_idle ? memAdrs[AW-1:0] : r_adr;
  assign w_wd  = w_idle ? memDataWD       : r_wd;

  assign w_to_resp = (w_idle && req && (WAIT_STATES == 0)) ||
                     ((r_state == WAIT) && (r_cnt == 4'd1));

  lsu_align u_align (
    .i_adr      (w_adr[1:0]),
    .i_funct3   (w_f3),
    .i_wd       (w_wd),
    .i_rword    (r_mem[w_adr[AW-1:2]]),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata),
    .o_misalign (w_mis)
  );

  assign busy      = ~reset & ((w_idle & req) | (r_state == WAIT));
  assign ack       = r_ack;
  assign misalign  = r_mis;
  assign memDataRD = r_rd;

  // Request FSM, wait counter and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_mis   <= 1'b0;
      r_rd    <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: if (req) begin
          r_we  <= we;
          r_f3  <= funct3;
          r_adr <= memAdrs[AW-1:0];
          r_wd  <= memDataWD;
          if (WAIT_STATES == 0) begin
            r_state <= RESP;
          end else begin
            r_state <= WAIT;
            r_cnt   <= 4'(WAIT_STATES);
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= RESP;
        end
        default: r_state <= IDLE;  // RESP ignores req
      endcase
      if (w_to_resp) begin
        r_ack <= 1'b1;
        r_mis <= w_mis;
        r_rd  <= w_rdata;
      end
    end
  end

  // Byte-lane store commit; blocked by reset so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (!reset && w_to_resp && w_we) begin
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_adr[AW-1:2]][8*i +: 8] <= w_wdata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus random traffic checked
// against a byte-addressed memory model.
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [2:0]  f3;
  logic [31:0] adr, wd, rd;
  logic        ack, busy, mis;
  logic        req0, we0;
  logic [2:0]  f30;
  logic [31:0] adr0, wd0, rd0;
  logic        ack0, busy0, mis0;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] mdl [int];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(12), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .funct3(f3), .memAdrs(adr),
    .memDataWD(wd), .memDataRD(rd), .ack(ack), .busy(busy), .misalign(mis));

  data_mem_responder #(.ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .funct3(f30), .memAdrs(adr0),
    .memDataWD(wd0), .memDataRD(rd0), .ack(ack0), .busy(busy0), .misalign(mis0));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic int sz(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit bad(input logic [2:0] f, input logic [31:0] a);
    return (sz(f) == 0) || ((a % sz(f)) != 0);
  endfunction

  // Memory is 16 KiB; addresses alias modulo 0x4000.
  function automatic int key(input logic [31:0] a);
    return int'(a & 32'h3fff);
  endfunction

  function automatic logic [31:0] mdl_load(input logic [2:0] f, input logic [31:0] a);
    logic [31:0] v = 0;
    int n = sz(f);
    for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[key(a + i)];
    if (!f[2] && n < 4 && v[8*n-1]) v = v | (32'hffffffff << (8*n));
    return v;
  endfunction

  // One access on the WAIT_STATES=1 instance, fully checked against the model.
  task automatic acc(input bit w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input string tag);
    logic [31:0] exp_rd;
    bit exp_mis;
    int lat;
    exp_mis = bad(f, a);
    exp_rd  = (exp_mis || w) ? 32'h0 : mdl_load(f, a);
    @(negedge clk);
    req = 1; we = w; f3 = f; adr = a; wd = d;
    #1 chk({tag, ":busy0"}, 32'(busy), 1);
    @(posedge clk); #1;
    req = 0; we = 0; adr = $urandom; wd = $urandom;
    lat = 1;
    while (!ack && lat <= WS + 3) begin
      chk({tag, ":busyw"}, 32'(busy), 1);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ":lat"}, 32'(lat), 32'(1 + WS));
    chk({tag, ":busyr"}, 32'(busy), 0);
    chk({tag, ":mis"}, 32'(mis), 32'(exp_mis));
    if (!w || exp_mis) chk({tag, ":rd"}, rd, exp_rd);
    if (w && !exp_mis)
      for (int i = 0; i < sz(f); i++) mdl[key(a + i)] = d[8*i +: 8];
    @(posedge clk); #1;
    chk({tag, ":ackpulse"}, 32'(ack), 0);
    if (!w) chk({tag, ":rdhold"}, rd, exp_rd);
  endtask

  task automatic st0(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req0 = 1; we0 = 1; f30 = F3_W; adr0 = a; wd0 = d;
    @(posedge clk); #1;
    chk("ws0:st_ack", 32'(ack0), 1);
    req0 = 0; we0 = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1; req = 1; we = 1; f3 = F3_W; adr = 32'h100; wd = 0;
    req0 = 1; we0 = 0; f30 = F3_W; adr0 = 0; wd0 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:ack", 32'(ack), 0);
    chk("rst:mis", 32'(mis), 0);
    chk("rst:rd", rd, 0);
    chk("rst:busy", 32'(busy), 0);
    chk("rst:busy0", 32'(busy0), 0);
    chk("rst:rd0", rd0, 0);
    @(negedge clk);
    reset = 0; req = 0; we = 0; req0 = 0;

    // basic word, byte and half traffic
    acc(1, F3_W,  32'h100, 32'hDEADBEEF, "sw100");
    acc(0, F3_W,  32'h100, 0, "lw100");
    acc(1, F3_B,  32'h103, 32'h00000080, "sb103");
    acc(0, F3_B,  32'h103, 0, "lb103");
    acc(0, F3_BU, 32'h103, 0, "lbu103");
    acc(0, F3_W,  32'h100, 0, "lw100b");
    acc(1, F3_H,  32'h102, 32'h00008234, "sh102");
    acc(0, F3_H,  32'h102, 0, "lh102");
    acc(0, F3_HU, 32'h102, 0, "lhu102");
    acc(0, F3_W,  32'h100, 0, "lw100c");

    // error cases: no write, zero data
    acc(0, F3_W,  32'h101, 0, "lw101");
    acc(0, F3_H,  32'h103, 0, "lh103");
    acc(1, F3_H,  32'h101, 32'h1111, "sh101");
    acc(1, 3'b011, 32'h100, 32'h2222, "sf3_011");
    acc(0, 3'b110, 32'h100, 0, "lf3_110");
    acc(0, F3_W,  32'h100, 0, "lw100d");

    // address wrap at 16 KiB
    acc(0, F3_W,  32'h00004100, 0, "lwwrap");
    acc(1, F3_W,  32'hFFFFC104, 32'h01234567, "swwrap");
    acc(0, F3_W,  32'h104, 0, "lw104");

    // reset during WAIT of a store aborts it
    acc(1, F3_W, 32'h200, 32'h0, "sw200");
    @(negedge clk);
    req = 1; we = 1; f3 = F3_W; adr = 32'h200; wd = 32'h55;
    @(posedge clk); #1;
    req = 0; we = 0;
    chk("abort:ackw", 32'(ack), 0);
    reset = 1;
    #1 chk("abort:busyrst", 32'(busy), 0);
    @(posedge clk); #1;
    reset = 0;
    chk("abort:busy", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      chk("abort:noack", 32'(ack), 0);
      @(posedge clk); #1;
    end
    acc(0, F3_W, 32'h200, 0, "lw200");

    // reset and req together: request dropped
    @(negedge clk);
    reset = 1; req = 1; we = 1; adr = 32'h200; wd = 32'h77;
    @(posedge clk); #1;
    reset = 0; req = 0; we = 0;
    for (int i = 0; i < 3; i++) begin
      chk("rstreq:noack", 32'(ack), 0);
      chk("rstreq:busy", 32'(busy), 0);
      @(posedge clk); #1;
    end
    acc(0, F3_W, 32'h200, 0, "lw200b");

    // zero wait states, req held high across RESP
    st0(32'h100, 32'hA5A5_0101);
    st0(32'h104, 32'h5A5A_0404);
    @(negedge clk);
    req0 = 1; we0 = 0; f30 = F3_W; adr0 = 32'h100;
    #1 chk("ws0:busy0", 32'(busy0), 1);
    @(posedge clk); #1;
    chk("ws0:ack1", 32'(ack0), 1);
    chk("ws0:rd1", rd0, 32'hA5A5_0101);
    chk("ws0:busy1", 32'(busy0), 0);
    adr0 = 32'h104;
    @(posedge clk); #1;
    chk("ws0:ack2", 32'(ack0), 0);
    chk("ws0:busy2", 32'(busy0), 1);
    @(posedge clk); #1;
    chk("ws0:ack3", 32'(ack0), 1);
    chk("ws0:rd3", rd0, 32'h5A5A_0404);
    req0 = 0;

    // random traffic over a pre-initialised window, upper bits randomised
    for (int i = 0; i < 16; i++) acc(1, F3_W, 32'(i * 4), $urandom, "init");
    for (int i = 0; i < 150; i++)
      acc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          $urandom & 32'hFFFF_C03F, $urandom, "rnd");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
